// File: rtl/uitpg_ctrl.sv
// Pattern-mode scheduler for the TPG: counts frames on vsync rising edges and steps or holds the mode select.
// Latency: outputs update one clock after tpg_vs_i rises; cfg_ack_o pulses one clock after a write.
// Backpressure: none. Writes are always accepted; a newer pending write overwrites the older one.
// Optional feature macro: UITPG_CTRL_KEY_EN adds a debounced active-low step key on key_i.
module uitpg_ctrl #(
  parameter int FRAMES_PER_MODE = 128,
  parameter int NUM_MODES       = 16,
  parameter int DEBOUNCE_CYC    = 1000000
) (
  input  logic        tpg_clk_i,
  input  logic        tpg_rst_n_i,
  input  logic        tpg_vs_i,
  input  logic        cfg_wr_i,
  input  logic        cfg_auto_i,
  input  logic [3:0]  cfg_mode_i,
`ifdef UITPG_CTRL_KEY_EN
  input  logic        key_i,
`endif
  output logic        cfg_ack_o,
  output logic [3:0]  mode_o,
  output logic        mode_chg_o,
  output logic [15:0] frame_cnt_o
);

  localparam int             DW        = $clog2(FRAMES_PER_MODE) + 1;
  localparam logic [3:0]     MaxMode   = 4'(NUM_MODES - 1);
  localparam logic [DW-1:0]  DwellLast = DW'(FRAMES_PER_MODE - 1);

  // Reject parameter values that would make the counters or the mode wrap meaningless.
  if (FRAMES_PER_MODE < 1) begin : g_bad_fpm
    $error("FRAMES_PER_MODE must be >= 1");
  end
  if (NUM_MODES < 2 || NUM_MODES > 16) begin : g_bad_modes
    $error("NUM_MODES must be in 2..16");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYC must be >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_AUTO, ST_MANUAL} state_e;

  state_e         state_q, state_d;
  logic [3:0]     mode_q, mode_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic           chg_q, chg_d;
  logic [15:0]    frame_q;
  logic           vs_q;
  logic           vs_edge;
  logic           pend_vld_q, pend_auto_q;
  logic [3:0]     pend_mode_q;
  logic           ack_q;
  logic           wr_vld, wr_auto;
  logic [3:0]     wr_mode;
  logic [3:0]     cfg_mode_clamped;

  assign vs_edge          = tpg_vs_i & ~vs_q;
  assign cfg_mode_clamped = (cfg_mode_i > MaxMode) ? MaxMode : cfg_mode_i;

`ifdef UITPG_CTRL_KEY_EN
  localparam int            CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] DebLast = CW'(DEBOUNCE_CYC - 1);

  logic          key_s1_q, key_s2_q, key_stb_q;
  logic [CW-1:0] deb_cnt_q;
  logic          key_fall;
  logic [3:0]    step_base;

  // Synchronise the key and accept a new level only after it has differed for DEBOUNCE_CYC clocks.
  always_ff @(posedge tpg_clk_i or negedge tpg_rst_n_i) begin
    if (!tpg_rst_n_i) begin
      key_s1_q  <= 1'b1;
      key_s2_q  <= 1'b1;
      key_stb_q <= 1'b1;
      deb_cnt_q <= '0;
    end else begin
      key_s1_q <= key_i;
      key_s2_q <= key_s1_q;
      if (key_s2_q != key_stb_q) begin
        if (deb_cnt_q == DebLast) begin
          key_stb_q <= key_s2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // A debounced press steps from the mode that would be shown next; a host write in the same cycle wins.
  always_comb begin
    key_fall  = key_stb_q & ~key_s2_q & (deb_cnt_q == DebLast);
    step_base = pend_vld_q ? pend_mode_q : mode_q;
    wr_vld    = cfg_wr_i | key_fall;
    wr_mode   = cfg_wr_i ? cfg_mode_clamped : ((step_base == MaxMode) ? 4'd0 : step_base + 4'd1);
    wr_auto   = cfg_wr_i ? cfg_auto_i : 1'b0;
  end
`else
  // Only the host port can request a mode change.
  always_comb begin
    wr_vld  = cfg_wr_i;
    wr_mode = cfg_mode_clamped;
    wr_auto = cfg_auto_i;
  end
`endif

  // Hold the latest request until a frame boundary consumes it; a write on that same edge stays pending.
  always_ff @(posedge tpg_clk_i or negedge tpg_rst_n_i) begin
    if (!tpg_rst_n_i) begin
      vs_q        <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_auto_q <= 1'b0;
      pend_mode_q <= 4'd0;
      ack_q       <= 1'b0;
      frame_q     <= 16'd0;
    end else begin
      vs_q  <= tpg_vs_i;
      ack_q <= wr_vld;
      if (vs_edge) frame_q <= frame_q + 16'd1;
      if (vs_edge && pend_vld_q) pend_vld_q <= 1'b0;
      if (wr_vld) begin
        pend_vld_q  <= 1'b1;
        pend_mode_q <= wr_mode;
        pend_auto_q <= wr_auto;
      end
    end
  end

  // Next-state logic: everything moves only on a frame boundary, pending request first.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    chg_d   = 1'b0;
    if (vs_edge) begin
      if (pend_vld_q) begin
        mode_d  = pend_mode_q;
        state_d = pend_auto_q ? ST_AUTO : ST_MANUAL;
        dwell_d = '0;
        chg_d   = (pend_mode_q != mode_q);
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_AUTO;
            dwell_d = '0;
          end
          ST_AUTO: begin
            if (dwell_q == DwellLast) begin
              mode_d  = (mode_q == MaxMode) ? 4'd0 : mode_q + 4'd1;
              dwell_d = '0;
              chg_d   = 1'b1;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge tpg_clk_i or negedge tpg_rst_n_i) begin
    if (!tpg_rst_n_i) begin
      state_q <= ST_IDLE;
      mode_q  <= 4'd0;
      dwell_q <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      chg_q   <= chg_d;
    end
  end

  assign cfg_ack_o   = ack_q;
  assign mode_o      = mode_q;
  assign mode_chg_o  = chg_q;
  assign frame_cnt_o = frame_q;

endmodule
